rtu_link_ctrl: RTL and testbench

//  Half-duplex sequencer for the RS-485 transceiver model (byte-level tx_enable/tx_data/rx_enable/rx_data).

---
 rtl/rtu_link_pkg.sv | 21 ++
 rtl/rtu_gap_timer.sv | 38 +++
 rtl/rtu_link_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_rtu_link_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/rtu_link_pkg.sv
// Shared types and default timing for the Modbus RTU half-duplex link sequencer.
package rtu_link_pkg;

  localparam int unsigned BYTE_W          = 8;
  localparam int unsigned CNT_W           = 16;
  localparam int unsigned CHAR_CYCLES     = 16;
  localparam int unsigned T15_CYCLES      = 24;
  localparam int unsigned T35_CYCLES      = 56;
  localparam int unsigned DE_SETUP_CYCLES = 2;
  localparam int unsigned DE_HOLD_CYCLES  = 4;

  typedef enum logic [2:0] {
    SILENCE,
    IDLE,
    DE_SETUP,
    LOAD,
    SEND,
    DE_HOLD
  } link_state_e;

endpackage

// File: rtl/rtu_gap_timer.sv
// Shared gap/slot counter: saturates at T35, clears on demand, flags gaps and slot terminal count.
module rtu_gap_timer
  import rtu_link_pkg::*;
#(
  parameter int unsigned CW  = CNT_W,
  parameter int unsigned T15 = T15_CYCLES,
  parameter int unsigned T35 = T35_CYCLES
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  input  logic [CW-1:0] limit,
  output logic          gt_t15_c,
  output logic          tc_c
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q < CW'(T35))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign gt_t15_c = (cnt_q > CW'(T15));
  // Terminal count fires on the last cycle of a slot of 'limit' cycles.
  assign tc_c     = (cnt_q == (limit - CW'(1)));

endmodule

// File: rtl/rtu_link_ctrl.sv
// Half-duplex RS-485 sequencer: arbitrates TX frames against RX traffic with RTU timing.
module rtu_link_ctrl
  import rtu_link_pkg::*;
#(
  parameter int unsigned P_CHAR_CYCLES     = CHAR_CYCLES,
  parameter int unsigned P_T15_CYCLES      = T15_CYCLES,
  parameter int unsigned P_T35_CYCLES      = T35_CYCLES,
  parameter int unsigned P_DE_SETUP_CYCLES = DE_SETUP_CYCLES,
  parameter int unsigned P_DE_HOLD_CYCLES  = DE_HOLD_CYCLES,
  parameter int unsigned P_CNT_W           = CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_valid,
  input  logic [BYTE_W-1:0] tx_data,
  input  logic              tx_last,
  output logic              tx_ready,
  output logic              tx_underrun,
  output logic              rx_byte_valid,
  output logic [BYTE_W-1:0] rx_byte,
  output logic              rx_char_err,
  output logic              rx_frame_end,
  output logic              busy,
  output logic              xcvr_tx_enable,
  output logic [BYTE_W-1:0] xcvr_tx_data,
  output logic              xcvr_rx_enable,
  input  logic              xcvr_rx_valid,
  input  logic [BYTE_W-1:0] xcvr_rx_data
);

  link_state_e       state_q, state_d;
  logic              rx_seen_q, rx_seen_d;
  logic [BYTE_W-1:0] tx_byte_q, tx_byte_d;
  logic              tx_last_q, tx_last_d;
  logic              tx_ready_q, tx_ready_d;
  logic              tx_underrun_q, tx_underrun_d;
  logic              rx_byte_valid_q, rx_byte_valid_d;
  logic [BYTE_W-1:0] rx_byte_q, rx_byte_d;
  logic              rx_char_err_q, rx_char_err_d;
  logic              rx_frame_end_q, rx_frame_end_d;
  logic              busy_q, busy_d;
  logic              xcvr_tx_enable_q, xcvr_tx_enable_d;
  logic [BYTE_W-1:0] xcvr_tx_data_q, xcvr_tx_data_d;
  logic              xcvr_rx_enable_q, xcvr_rx_enable_d;

  logic               cnt_clr;
  logic [P_CNT_W-1:0] slot_limit;
  logic               gt_t15_c, tc_c;
  logic               rx_acc, tx_hs;

  assign rx_acc = xcvr_rx_valid && xcvr_rx_enable_q;
  assign tx_hs  = tx_valid && tx_ready_q;

  rtu_gap_timer #(
    .CW  (P_CNT_W),
    .T15 (P_T15_CYCLES),
    .T35 (P_T35_CYCLES)
  ) u_gap_timer (
    .clk      (clk),
    .reset    (reset),
    .clr      (cnt_clr),
    .en       (1'b1),
    .limit    (slot_limit),
    .gt_t15_c (gt_t15_c),
    .tc_c     (tc_c)
  );

  // Slot length of the current state for the terminal-count compare.
  always_comb begin
    slot_limit = P_CNT_W'(P_T35_CYCLES);
    case (state_q)
      DE_SETUP: slot_limit = P_CNT_W'(P_DE_SETUP_CYCLES);
      LOAD:     slot_limit = P_CNT_W'(P_T15_CYCLES);
      SEND:     slot_limit = P_CNT_W'(P_CHAR_CYCLES);
      DE_HOLD:  slot_limit = P_CNT_W'(P_DE_HOLD_CYCLES);
      default:  slot_limit = P_CNT_W'(P_T35_CYCLES);
    endcase
  end

  always_comb begin
    state_d        = state_q;
    rx_seen_d      = rx_seen_q;
    tx_byte_d      = tx_byte_q;
    tx_last_d      = tx_last_q;
    cnt_clr        = 1'b0;
    tx_underrun_d  = 1'b0;
    rx_frame_end_d = 1'b0;

    case (state_q)
      SILENCE: begin
        if (rx_acc) begin
          cnt_clr   = 1'b1;
          rx_seen_d = 1'b1;
        end else if (tc_c) begin
          state_d        = IDLE;
          cnt_clr        = 1'b1;
          rx_frame_end_d = rx_seen_q;
          rx_seen_d      = 1'b0;
        end
      end
      IDLE: begin
        // Remote traffic wins over a simultaneous local request.
        if (rx_acc) begin
          state_d   = SILENCE;
          cnt_clr   = 1'b1;
          rx_seen_d = 1'b1;
        end else if (tx_valid) begin
          state_d = DE_SETUP;
          cnt_clr = 1'b1;
        end
      end
      DE_SETUP: begin
        if (tc_c) begin
          state_d = LOAD;
          cnt_clr = 1'b1;
        end
      end
      LOAD: begin
        if (tx_hs) begin
          state_d   = SEND;
          cnt_clr   = 1'b1;
          tx_byte_d = tx_data;
          tx_last_d = tx_last;
        end else if (tc_c) begin
          state_d       = DE_HOLD;
          cnt_clr       = 1'b1;
          tx_underrun_d = 1'b1;
        end
      end
      SEND: begin
        if (tc_c) begin
          state_d = tx_last_q ? DE_HOLD : LOAD;
          cnt_clr = 1'b1;
        end
      end
      DE_HOLD: begin
        if (tc_c) begin
          state_d   = SILENCE;
          cnt_clr   = 1'b1;
          rx_seen_d = 1'b0;
        end
      end
      default: begin
        state_d = SILENCE;
        cnt_clr = 1'b1;
      end
    endcase

    // Bus controls are decoded from the next state so they track state_q exactly.
    tx_ready_d       = (state_d == LOAD);
    busy_d           = (state_d != IDLE);
    xcvr_tx_enable_d = (state_d == SEND);
    xcvr_tx_data_d   = (state_d == SEND) ? tx_byte_d : '0;
    xcvr_rx_enable_d = (state_d == SILENCE) || (state_d == IDLE);
  end

  always_comb begin
    rx_byte_valid_d = rx_acc;
    rx_byte_d       = rx_acc ? xcvr_rx_data : rx_byte_q;
    rx_char_err_d   = rx_acc && (state_q == SILENCE) && rx_seen_q && gt_t15_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= SILENCE;
      rx_seen_q        <= 1'b0;
      tx_byte_q        <= '0;
      tx_last_q        <= 1'b0;
      tx_ready_q       <= 1'b0;
      tx_underrun_q    <= 1'b0;
      rx_byte_valid_q  <= 1'b0;
      rx_byte_q        <= '0;
      rx_char_err_q    <= 1'b0;
      rx_frame_end_q   <= 1'b0;
      busy_q           <= 1'b1;
      xcvr_tx_enable_q <= 1'b0;
      xcvr_tx_data_q   <= '0;
      xcvr_rx_enable_q <= 1'b1;
    end else begin
      state_q          <= state_d;
      rx_seen_q        <= rx_seen_d;
      tx_byte_q        <= tx_byte_d;
      tx_last_q        <= tx_last_d;
      tx_ready_q       <= tx_ready_d;
      tx_underrun_q    <= tx_underrun_d;
      rx_byte_valid_q  <= rx_byte_valid_d;
      rx_byte_q        <= rx_byte_d;
      rx_char_err_q    <= rx_char_err_d;
      rx_frame_end_q   <= rx_frame_end_d;
      busy_q           <= busy_d;
      xcvr_tx_enable_q <= xcvr_tx_enable_d;
      xcvr_tx_data_q   <= xcvr_tx_data_d;
      xcvr_rx_enable_q <= xcvr_rx_enable_d;
    end
  end

  assign tx_ready       = tx_ready_q;
  assign tx_underrun    = tx_underrun_q;
  assign rx_byte_valid  = rx_byte_valid_q;
  assign rx_byte        = rx_byte_q;
  assign rx_char_err    = rx_char_err_q;
  assign rx_frame_end   = rx_frame_end_q;
  assign busy           = busy_q;
  assign xcvr_tx_enable = xcvr_tx_enable_q;
  assign xcvr_tx_data   = xcvr_tx_data_q;
  assign xcvr_rx_enable = xcvr_rx_enable_q;

endmodule

// File: tb/tb_rtu_link_ctrl.sv
// Directed bench for rtu_link_ctrl: reset, TX frame, RX timing, underrun, collision and abort.
module tb_rtu_link_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_last = 1'b0;
  logic       tx_ready, tx_underrun, rx_byte_valid, rx_char_err, rx_frame_end, busy;
  logic [7:0] rx_byte;
  logic       xcvr_tx_enable, xcvr_rx_enable;
  logic [7:0] xcvr_tx_data;
  logic       xcvr_rx_valid = 1'b0;
  logic [7:0] xcvr_rx_data = 8'h00;

  int vectors = 0;
  int miscompares = 0;

  rtu_link_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .tx_valid       (tx_valid),
    .tx_data        (tx_data),
    .tx_last        (tx_last),
    .tx_ready       (tx_ready),
    .tx_underrun    (tx_underrun),
    .rx_byte_valid  (rx_byte_valid),
    .rx_byte        (rx_byte),
    .rx_char_err    (rx_char_err),
    .rx_frame_end   (rx_frame_end),
    .busy           (busy),
    .xcvr_tx_enable (xcvr_tx_enable),
    .xcvr_tx_data   (xcvr_tx_data),
    .xcvr_rx_enable (xcvr_rx_enable),
    .xcvr_rx_valid  (xcvr_rx_valid),
    .xcvr_rx_data   (xcvr_rx_data)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are then stable for sampling and inputs apply to the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int n;
    int bad;
    int fe;
    reset = 1'b1;
    step();
    step();
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL reset_busy: got %b want 1", busy); end
    vectors++; if (xcvr_rx_enable !== 1'b1) begin miscompares++; $display("FAIL reset_rx_en: got %b want 1", xcvr_rx_enable); end
    vectors++; if ({tx_ready, tx_underrun, xcvr_tx_enable, rx_byte_valid, rx_frame_end, rx_char_err} !== 6'b0) begin
      miscompares++; $display("FAIL reset_flags: got %b want 000000", {tx_ready, tx_underrun, xcvr_tx_enable, rx_byte_valid, rx_frame_end, rx_char_err});
    end
    vectors++; if (xcvr_tx_data !== 8'h00) begin miscompares++; $display("FAIL reset_tx_data: got %h want 00", xcvr_tx_data); end
    reset = 1'b0;
    n = 0; bad = 0; fe = 0;
    while (busy === 1'b1 && n < 200) begin
      if (xcvr_rx_enable !== 1'b1) bad++;
      if (rx_frame_end !== 1'b0) fe++;
      n++;
      step();
    end
    vectors++; if (n !== 56) begin miscompares++; $display("FAIL reset_silence_len: got %0d want 56", n); end
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL reset_rx_en_hold: got %0d want 0", bad); end
    vectors++; if (fe !== 0) begin miscompares++; $display("FAIL reset_no_frame_end: got %0d want 0", fe); end
  endtask

  task automatic test_tx_frame();
    logic [7:0] frame [3];
    int hs, en, bad, rdy, low, bsy, rxv, fe;
    bit started, pend;
    frame[0] = 8'h01; frame[1] = 8'h03; frame[2] = 8'h00;
    hs = 0; en = 0; bad = 0; rdy = 0; low = 0; bsy = 0; rxv = 0; fe = 0;
    started = 1'b0; pend = 1'b0;
    tx_valid = 1'b1; tx_data = frame[0]; tx_last = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (busy === 1'b1) started = 1'b1;
      if (started && busy === 1'b0) break;
      if (busy === 1'b1) bsy++;
      if (xcvr_tx_enable === 1'b1) begin
        en++;
        if (hs == 0 || xcvr_tx_data !== frame[hs-1]) bad++;
      end else if (xcvr_tx_data !== 8'h00) begin
        bad++;
      end
      if (xcvr_rx_enable !== 1'b1) low++;
      if (tx_ready === 1'b1) begin rdy++; if (tx_valid) pend = 1'b1; end
      if (rx_byte_valid === 1'b1) rxv++;
      if (rx_frame_end === 1'b1) fe++;
      // A stray strobe while driving must be ignored.
      xcvr_rx_valid = (en == 10) && (xcvr_tx_enable === 1'b1);
      xcvr_rx_data = 8'h5A;
      step();
      if (pend) begin
        pend = 1'b0;
        hs++;
        if (hs < 3) begin tx_data = frame[hs]; tx_last = (hs == 2); end
        else begin tx_valid = 1'b0; tx_last = 1'b0; end
      end
    end
    xcvr_rx_valid = 1'b0;
    vectors++; if (hs !== 3) begin miscompares++; $display("FAIL tx_handshakes: got %0d want 3", hs); end
    vectors++; if (rdy !== 3) begin miscompares++; $display("FAIL tx_ready_cycles: got %0d want 3", rdy); end
    vectors++; if (en !== 48) begin miscompares++; $display("FAIL tx_enable_cycles: got %0d want 48", en); end
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL tx_data_bytes: got %0d bad want 0", bad); end
    vectors++; if (low !== 57) begin miscompares++; $display("FAIL tx_rx_en_low: got %0d want 57", low); end
    vectors++; if (bsy !== 113) begin miscompares++; $display("FAIL tx_busy_cycles: got %0d want 113", bsy); end
    vectors++; if (rxv !== 0) begin miscompares++; $display("FAIL tx_rx_ignored: got %0d want 0", rxv); end
    vectors++; if (fe !== 0) begin miscompares++; $display("FAIL tx_no_frame_end: got %0d want 0", fe); end
  endtask

  task automatic test_rx_pair();
    int fe;
    int at;
    xcvr_rx_data = 8'h11; xcvr_rx_valid = 1'b1;
    step();
    xcvr_rx_valid = 1'b0;
    vectors++; if ({rx_byte_valid, rx_char_err} !== 2'b10 || rx_byte !== 8'h11) begin
      miscompares++; $display("FAIL rx1_fwd: got v/e=%b byte=%h want 10 11", {rx_byte_valid, rx_char_err}, rx_byte);
    end
    repeat (15) step();
    vectors++; if (rx_byte_valid !== 1'b0 || rx_byte !== 8'h11) begin
      miscompares++; $display("FAIL rx1_hold: got v=%b byte=%h want 0 11", rx_byte_valid, rx_byte);
    end
    xcvr_rx_data = 8'h22; xcvr_rx_valid = 1'b1;
    step();
    xcvr_rx_valid = 1'b0;
    vectors++; if ({rx_byte_valid, rx_char_err} !== 2'b10 || rx_byte !== 8'h22) begin
      miscompares++; $display("FAIL rx2_fwd: got v/e=%b byte=%h want 10 22", {rx_byte_valid, rx_char_err}, rx_byte);
    end
    fe = 0; at = -1;
    for (int c = 1; c <= 80; c++) begin
      step();
      if (rx_frame_end === 1'b1) begin fe++; if (at < 0) at = c; end
    end
    vectors++; if (fe !== 1) begin miscompares++; $display("FAIL rx_frame_end_count: got %0d want 1", fe); end
    vectors++; if (at !== 56) begin miscompares++; $display("FAIL rx_frame_end_time: got %0d want 56", at); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rx_back_idle: got %b want 0", busy); end
  endtask

  task automatic test_char_err();
    xcvr_rx_data = 8'h11; xcvr_rx_valid = 1'b1;
    step();
    xcvr_rx_valid = 1'b0;
    vectors++; if (rx_char_err !== 1'b0) begin miscompares++; $display("FAIL cerr_first: got %b want 0", rx_char_err); end
    repeat (29) step();
    xcvr_rx_data = 8'h22; xcvr_rx_valid = 1'b1;
    step();
    xcvr_rx_valid = 1'b0;
    vectors++; if ({rx_byte_valid, rx_char_err} !== 2'b11 || rx_byte !== 8'h22) begin
      miscompares++; $display("FAIL cerr_second: got v/e=%b byte=%h want 11 22", {rx_byte_valid, rx_char_err}, rx_byte);
    end
    step();
    vectors++; if (rx_char_err !== 1'b0) begin miscompares++; $display("FAIL cerr_pulse: got %b want 0", rx_char_err); end
    repeat (60) step();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL cerr_back_idle: got %b want 0", busy); end
  endtask

  task automatic test_underrun();
    int n, en, rdy, und, und_at, hold, bad, fe;
    tx_valid = 1'b1; tx_data = 8'hA5; tx_last = 1'b0;
    n = 0;
    while (tx_ready !== 1'b1 && n < 20) begin step(); n++; end
    vectors++; if (n !== 3) begin miscompares++; $display("FAIL und_load_latency: got %0d want 3", n); end
    step();
    tx_valid = 1'b0; tx_data = 8'h5A;
    en = 0; rdy = 0; und = 0; und_at = -1; hold = 0; bad = 0;
    for (int c = 0; c < 100; c++) begin
      if (xcvr_rx_enable === 1'b1) break;
      if (xcvr_tx_enable === 1'b1) begin en++; if (xcvr_tx_data !== 8'hA5) bad++; end
      if (tx_ready === 1'b1) rdy++;
      if (tx_underrun === 1'b1) begin und++; if (und_at < 0) und_at = c; end
      if (xcvr_tx_enable !== 1'b1 && tx_ready !== 1'b1) hold++;
      step();
    end
    vectors++; if (en !== 16 || bad !== 0) begin miscompares++; $display("FAIL und_send: got %0d cycles %0d bad want 16 0", en, bad); end
    vectors++; if (rdy !== 24) begin miscompares++; $display("FAIL und_load_cycles: got %0d want 24", rdy); end
    vectors++; if (und !== 1 || und_at !== 40) begin miscompares++; $display("FAIL und_pulse: got %0d at %0d want 1 at 40", und, und_at); end
    vectors++; if (hold !== 4) begin miscompares++; $display("FAIL und_de_hold: got %0d want 4", hold); end
    vectors++; if (busy !== 1'b1 || xcvr_rx_enable !== 1'b1) begin
      miscompares++; $display("FAIL und_silence: got busy=%b rx_en=%b want 1 1", busy, xcvr_rx_enable);
    end
    fe = 0;
    repeat (60) begin step(); if (rx_frame_end === 1'b1) fe++; end
    vectors++; if (fe !== 0 || busy !== 1'b0) begin miscompares++; $display("FAIL und_own_frame: got fe=%0d busy=%b want 0 0", fe, busy); end
  endtask

  task automatic test_collision_abort();
    int n;
    tx_valid = 1'b1; tx_data = 8'h77; tx_last = 1'b1;
    xcvr_rx_data = 8'h3C; xcvr_rx_valid = 1'b1;
    step();
    xcvr_rx_valid = 1'b0;
    vectors++; if (rx_byte_valid !== 1'b1 || rx_byte !== 8'h3C || tx_ready !== 1'b0) begin
      miscompares++; $display("FAIL col_rx_wins: got v=%b byte=%h rdy=%b want 1 3c 0", rx_byte_valid, rx_byte, tx_ready);
    end
    n = 0;
    while (tx_ready !== 1'b1 && n < 100) begin step(); n++; end
    vectors++; if (n !== 59) begin miscompares++; $display("FAIL col_ready_delay: got %0d want 59", n); end
    step();
    tx_valid = 1'b0;
    vectors++; if (xcvr_tx_enable !== 1'b1 || xcvr_tx_data !== 8'h77) begin
      miscompares++; $display("FAIL col_send: got en=%b data=%h want 1 77", xcvr_tx_enable, xcvr_tx_data);
    end
    repeat (5) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    vectors++; if (xcvr_tx_enable !== 1'b0 || xcvr_tx_data !== 8'h00) begin
      miscompares++; $display("FAIL abort_tx_off: got en=%b data=%h want 0 00", xcvr_tx_enable, xcvr_tx_data);
    end
    vectors++; if (busy !== 1'b1 || xcvr_rx_enable !== 1'b1 || tx_underrun !== 1'b0 || tx_ready !== 1'b0) begin
      miscompares++; $display("FAIL abort_silence: got busy=%b rx_en=%b und=%b rdy=%b want 1 1 0 0", busy, xcvr_rx_enable, tx_underrun, tx_ready);
    end
    n = 0;
    while (busy === 1'b1 && n < 200) begin step(); n++; end
    vectors++; if (n !== 56) begin miscompares++; $display("FAIL abort_silence_len: got %0d want 56", n); end
  endtask

  initial begin
    test_reset();
    test_tx_frame();
    test_rx_pair();
    test_char_err();
    test_underrun();
    test_collision_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
